// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO bridge: register offsets inside the
// 64-word I/O window, STATUS layout and the decoded register selector.
package mmio_pkg;

  localparam logic [5:0] OFF_IN     = 6'h00;
  localparam logic [5:0] OFF_OUT    = 6'h10;
  localparam logic [5:0] OFF_STATUS = 6'h20;
  localparam logic [5:0] OFF_PERIOD = 6'h21;
  localparam logic [5:0] OFF_COUNT  = 6'h22;
  localparam logic [5:0] OFF_TICKS  = 6'h23;

  localparam int unsigned FLAG_BITS = 16;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_IN,
    REG_OUT,
    REG_STATUS,
    REG_PERIOD,
    REG_COUNT,
    REG_TICKS
  } io_reg_e;

endpackage

// File: rtl/mmio_timer.sv
// Programmable game-clock timer: PERIOD/COUNT/TICKS registers and a
// registered one-cycle tick pulse every PERIOD cycles (PERIOD=0 disables).
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              period_we,
  input  logic              ticks_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] period,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] ticks,
  output logic              tick
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period <= '0;
      count  <= '0;
      ticks  <= '0;
      tick   <= 1'b0;
    end else begin
      if (period_we) begin
        period <= wdata;
        count  <= '0;
        tick   <= 1'b0;
      end else if (period == '0) begin
        count <= '0;
        tick  <= 1'b0;
      end else if (count == period - ONE) begin
        count <= '0;
        tick  <= 1'b1;
        ticks <= ticks + ONE;
      end else begin
        count <= count + ONE;
        tick  <= 1'b0;
      end
      // A software clear beats the increment landing on the same edge.
      if (ticks_we) ticks <= '0;
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Memory-mapped I/O bridge between the processor data port and dmem: low
// addresses pass to dmem, the window at IO_BASE hits capture/output/timer regs.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 12,
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       NUM_IN  = 4,
  parameter int unsigned       NUM_OUT = 4,
  parameter logic [ADDR_W-1:0] IO_BASE = 12'hF00
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic                      cpu_wren,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_wren,
  input  logic [DATA_W-1:0]         mem_q,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_strobe,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic                      tick
);

  logic              sel_io;
  logic              in_window;
  logic [ADDR_W-1:0] io_off;
  logic [5:0]        off6;
  logic [3:0]        idx;
  io_reg_e           reg_sel;

  logic [DATA_W-1:0] in_regs  [NUM_IN];
  logic [DATA_W-1:0] out_regs [NUM_OUT];
  logic [NUM_IN-1:0] flag;
  logic [NUM_IN-1:0] ovf;
  logic [NUM_IN-1:0] clr_flag;
  logic [NUM_IN-1:0] clr_ovf;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] io_mux;
  logic [DATA_W-1:0] period;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] ticks;
  logic              status_we;
  logic              out_we;

  assign sel_io    = (cpu_addr >= IO_BASE);
  assign io_off    = cpu_addr - IO_BASE;
  assign off6      = io_off[5:0];
  assign idx       = io_off[3:0];
  assign in_window = sel_io && (io_off[ADDR_W-1:6] == '0);

  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign mem_wren  = cpu_wren & ~sel_io;

  always_comb begin
    reg_sel = REG_NONE;
    if (in_window) begin
      case (off6[5:4])
        OFF_IN[5:4]:  if (32'(idx) < NUM_IN)  reg_sel = REG_IN;
        OFF_OUT[5:4]: if (32'(idx) < NUM_OUT) reg_sel = REG_OUT;
        default: begin
          case (off6)
            OFF_STATUS: reg_sel = REG_STATUS;
            OFF_PERIOD: reg_sel = REG_PERIOD;
            OFF_COUNT:  reg_sel = REG_COUNT;
            OFF_TICKS:  reg_sel = REG_TICKS;
            default:    reg_sel = REG_NONE;
          endcase
        end
      endcase
    end
  end

  assign status_we = cpu_wren && (reg_sel == REG_STATUS);
  assign out_we    = cpu_wren && (reg_sel == REG_OUT);
  assign clr_flag  = status_we ? cpu_wdata[NUM_IN-1:0] : '0;
  assign clr_ovf   = status_we ? cpu_wdata[FLAG_BITS +: NUM_IN] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_IN; i++) in_regs[i] <= '0;
      for (int unsigned j = 0; j < NUM_OUT; j++) out_regs[j] <= '0;
      flag <= '0;
      ovf  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        // Capture beats a same-cycle clear; ovf then only records a strobe
        // that lands on a flag software has not yet acknowledged.
        if (in_strobe[i]) begin
          in_regs[i] <= in_data[i*DATA_W +: DATA_W];
          flag[i]    <= 1'b1;
          if (flag[i] && !clr_flag[i]) ovf[i] <= 1'b1;
          else if (clr_ovf[i] && !clr_flag[i]) ovf[i] <= 1'b0;
        end else begin
          if (clr_flag[i]) flag[i] <= 1'b0;
          if (clr_ovf[i]) ovf[i] <= 1'b0;
        end
      end
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
        if (out_we && (32'(idx) == j)) out_regs[j] <= cpu_wdata;
      end
    end
  end

  always_comb begin
    status_word = '0;
    status_word[NUM_IN-1:0]         = flag;
    status_word[FLAG_BITS +: NUM_IN] = ovf;
  end

  always_comb begin
    io_mux = '0;
    case (reg_sel)
      REG_IN: begin
        for (int unsigned i = 0; i < NUM_IN; i++)
          if (32'(idx) == i) io_mux = in_regs[i];
      end
      REG_OUT: begin
        for (int unsigned j = 0; j < NUM_OUT; j++)
          if (32'(idx) == j) io_mux = out_regs[j];
      end
      REG_STATUS: io_mux = status_word;
      REG_PERIOD: io_mux = period;
      REG_COUNT:  io_mux = count;
      REG_TICKS:  io_mux = ticks;
      default:    io_mux = '0;
    endcase
  end

  assign cpu_rdata = sel_io ? io_mux : mem_q;

  always_comb begin
    out_data = '0;
    for (int unsigned j = 0; j < NUM_OUT; j++) out_data[j*DATA_W +: DATA_W] = out_regs[j];
  end

  mmio_timer #(
    .DATA_W(DATA_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .period_we(cpu_wren && (reg_sel == REG_PERIOD)),
    .ticks_we (cpu_wren && (reg_sel == REG_TICKS)),
    .wdata    (cpu_wdata),
    .period   (period),
    .count    (count),
    .ticks    (ticks),
    .tick     (tick)
  );

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: a vector table for decode/capture/status
// behaviour plus hand sequences for timer, output timing and async reset.
module tb_mmio_bridge;

  logic         clock = 1'b0;
  logic         reset;
  logic [11:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_wren;
  logic [31:0]  cpu_rdata;
  logic [11:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_wren;
  logic [31:0]  mem_q;
  logic [127:0] in_data;
  logic [3:0]   in_strobe;
  logic [127:0] out_data;
  logic         tick;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign mem_q = 32'hA5A5_0000 | {20'h0, cpu_addr};

  mmio_bridge #(
    .ADDR_W (12),
    .DATA_W (32),
    .NUM_IN (4),
    .NUM_OUT(4),
    .IO_BASE(12'hF00)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_wren (cpu_wren),
    .cpu_rdata(cpu_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wren (mem_wren),
    .mem_q    (mem_q),
    .in_data  (in_data),
    .in_strobe(in_strobe),
    .out_data (out_data),
    .tick     (tick)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [3:0]  strobe;
    logic [31:0] sdata;
    logic [31:0] exp_rd;
    logic        exp_mwe;
  } vec_t;

  vec_t vecs [36];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_in(input logic [3:0] strobe, input logic [31:0] sdata);
    in_strobe = strobe;
    for (int i = 0; i < 4; i++)
      in_data[i*32 +: 32] = strobe[i] ? sdata : (32'hBAD0_0000 | 32'(i));
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wren  = 1'b1;
    @(posedge clock);
    #1;
    cpu_wren = 1'b0;
  endtask

  initial begin
    // Reads see register state before the vector's own edge takes effect.
    vecs[0]  = '{12'h010, 32'hDEADBEEF, 1'b1, 4'h0, 32'h0,  32'hA5A5_0010, 1'b1};
    vecs[1]  = '{12'hF11, 32'h12,       1'b1, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[2]  = '{12'hF11, 32'h0,        1'b0, 4'h0, 32'h0,  32'h12,        1'b0};
    vecs[3]  = '{12'hF02, 32'h0,        1'b0, 4'h4, 32'h41, 32'h0,         1'b0};
    vecs[4]  = '{12'hF02, 32'h0,        1'b0, 4'h0, 32'h0,  32'h41,        1'b0};
    vecs[5]  = '{12'hF20, 32'h0,        1'b0, 4'h0, 32'h0,  32'h0000_0004, 1'b0};
    vecs[6]  = '{12'hF20, 32'h0,        1'b0, 4'h4, 32'h42, 32'h0000_0004, 1'b0};
    vecs[7]  = '{12'hF02, 32'h0,        1'b0, 4'h0, 32'h0,  32'h42,        1'b0};
    vecs[8]  = '{12'hF20, 32'h0004_0004, 1'b1, 4'h0, 32'h0, 32'h0004_0004, 1'b0};
    vecs[9]  = '{12'hF20, 32'h0,        1'b0, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[10] = '{12'hF05, 32'hFFFFFFFF, 1'b1, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[11] = '{12'hF3F, 32'hFFFFFFFF, 1'b1, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[12] = '{12'hF40, 32'h1,        1'b1, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[13] = '{12'hF14, 32'h77,       1'b1, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[14] = '{12'hF14, 32'h0,        1'b0, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[15] = '{12'hF00, 32'h0,        1'b0, 4'h1, 32'h99, 32'h0,         1'b0};
    vecs[16] = '{12'hF20, 32'h1,        1'b1, 4'h1, 32'h98, 32'h0000_0001, 1'b0};
    vecs[17] = '{12'hF20, 32'h0,        1'b0, 4'h0, 32'h0,  32'h0000_0001, 1'b0};
    vecs[18] = '{12'hF00, 32'h1234,     1'b1, 4'h0, 32'h0,  32'h98,        1'b0};
    vecs[19] = '{12'hF00, 32'h0,        1'b0, 4'h0, 32'h0,  32'h98,        1'b0};
    vecs[20] = '{12'hF22, 32'h5,        1'b1, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[21] = '{12'hF21, 32'h0,        1'b0, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[22] = '{12'hF20, 32'h1,        1'b1, 4'h0, 32'h0,  32'h0000_0001, 1'b0};
    vecs[23] = '{12'hF20, 32'h0,        1'b0, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[24] = '{12'hF13, 32'hCAFEF00D, 1'b1, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[25] = '{12'hF13, 32'h0,        1'b0, 4'h0, 32'h0,  32'hCAFEF00D,  1'b0};
    vecs[26] = '{12'hFFF, 32'h0,        1'b0, 4'h0, 32'h0,  32'h0,         1'b0};
    vecs[27] = '{12'h123, 32'h0,        1'b0, 4'h0, 32'h0,  32'hA5A5_0123, 1'b0};
    vecs[28] = '{12'hF20, 32'h0,        1'b0, 4'hB, 32'h11, 32'h0,         1'b0};
    vecs[29] = '{12'hF20, 32'h0,        1'b0, 4'h0, 32'h0,  32'h0000_000B, 1'b0};
    vecs[30] = '{12'hF03, 32'h0,        1'b0, 4'h0, 32'h0,  32'h11,        1'b0};
    vecs[31] = '{12'hF02, 32'h0,        1'b0, 4'h0, 32'h0,  32'h42,        1'b0};
    vecs[32] = '{12'hF01, 32'h0,        1'b0, 4'h2, 32'h22, 32'h11,        1'b0};
    vecs[33] = '{12'hF20, 32'h0,        1'b0, 4'h0, 32'h0,  32'h0002_000B, 1'b0};
    vecs[34] = '{12'hF20, 32'h0002_0000, 1'b1, 4'h0, 32'h0, 32'h0002_000B, 1'b0};
    vecs[35] = '{12'hF20, 32'h0,        1'b0, 4'h0, 32'h0,  32'h0000_000B, 1'b0};

    reset     = 1'b0;
    cpu_addr  = 12'hF20;
    cpu_wdata = '0;
    cpu_wren  = 1'b0;
    drive_in(4'h0, 32'h0);
    #1;
    check("reset_status", 128'(cpu_rdata), 128'h0);
    check("reset_out", out_data, 128'h0);
    check("reset_tick", 128'(tick), 128'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int v = 0; v < 36; v++) begin
      @(negedge clock);
      cpu_addr  = vecs[v].addr;
      cpu_wdata = vecs[v].wdata;
      cpu_wren  = vecs[v].wren;
      drive_in(vecs[v].strobe, vecs[v].sdata);
      #1;
      check($sformatf("vec%0d_rdata", v), 128'(cpu_rdata), 128'(vecs[v].exp_rd));
      check($sformatf("vec%0d_mem_wren", v), 128'(mem_wren), 128'(vecs[v].exp_mwe));
      check($sformatf("vec%0d_mem_addr", v), 128'(mem_addr), 128'(vecs[v].addr));
      check($sformatf("vec%0d_mem_wdata", v), 128'(mem_wdata), 128'(vecs[v].wdata));
      @(posedge clock);
    end
    @(negedge clock);
    cpu_wren = 1'b0;
    drive_in(4'h0, 32'h0);

    check("out_slice0", 128'(out_data[31:0]), 128'h0);
    check("out_slice1", 128'(out_data[63:32]), 128'h12);
    check("out_slice2", 128'(out_data[95:64]), 128'h0);
    check("out_slice3", 128'(out_data[127:96]), 128'hCAFEF00D);

    // Output register becomes visible one edge after the write.
    cpu_addr  = 12'hF10;
    cpu_wdata = 32'h5;
    cpu_wren  = 1'b1;
    #1;
    check("out0_before_edge", 128'(out_data[31:0]), 128'h0);
    @(posedge clock);
    #1;
    cpu_wren = 1'b0;
    check("out0_after_edge", 128'(out_data[31:0]), 128'h5);

    // PERIOD=3 written at E0: ticks after E3, E6, E9, E12; TICKS cleared at E12.
    cpu_write(12'hF21, 32'h3);
    check("timer_e0_tick", 128'(tick), 128'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 12) begin
        cpu_addr  = 12'hF23;
        cpu_wdata = 32'h55;
        cpu_wren  = 1'b1;
      end else begin
        cpu_addr = 12'hF22;
        cpu_wren = 1'b0;
      end
      @(posedge clock);
      #1;
      cpu_wren = 1'b0;
      check($sformatf("timer_e%0d_tick", k), 128'(tick), 128'((k % 3) == 0));
      cpu_addr = 12'hF22;
      #1;
      check($sformatf("timer_e%0d_count", k), 128'(cpu_rdata), 128'(k % 3));
      if (k == 9) begin
        cpu_addr = 12'hF23;
        #1;
        check("timer_ticks_e9", 128'(cpu_rdata), 128'h3);
      end
    end
    cpu_addr = 12'hF23;
    #1;
    check("timer_ticks_cleared", 128'(cpu_rdata), 128'h0);

    cpu_write(12'hF21, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("period1_tick%0d", k), 128'(tick), 128'h1);
    end

    cpu_write(12'hF21, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check("disabled_tick", 128'(tick), 128'h0);
    cpu_addr = 12'hF22;
    #1;
    check("disabled_count", 128'(cpu_rdata), 128'h0);

    // Asynchronous reset mid-run with live timer and output state.
    cpu_write(12'hF21, 32'h5);
    cpu_write(12'hF10, 32'h7);
    repeat (2) @(posedge clock);
    #1;
    check("pre_reset_out0", 128'(out_data[31:0]), 128'h7);
    cpu_addr = 12'hF20;
    reset = 1'b0;
    #1;
    check("async_out", out_data, 128'h0);
    check("async_tick", 128'(tick), 128'h0);
    check("async_status", 128'(cpu_rdata), 128'h0);
    cpu_addr = 12'hF21;
    #1;
    check("async_period", 128'(cpu_rdata), 128'h0);
    cpu_addr = 12'hF02;
    #1;
    check("async_in2", 128'(cpu_rdata), 128'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    cpu_addr = 12'hF22;
    #1;
    check("post_reset_count", 128'(cpu_rdata), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
